regfile_sb: RTL and testbench

- Parametrised integer register file for the rv32i core, with a per-register busy scoreboard for pipeline hazard detection.
- Provides two combinational read ports and one synchronous write port, with an optional write-to-read bypass.
- Register 0 reads zero and is never busy.
- Sits between decode/issue (source reads, destination reservation) and writeback (results and busy release).

---
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bus between issue/writeback logic and the register file: two read ports,
// one writeback port, one reservation port and the pipeline flush.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wrt_en;
    logic [AW-1:0]   wrt_addr;
    logic [XLEN-1:0] wrt_data;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            flush;
    logic [AW:0]     busy_cnt;

    modport master (
        output rs1_addr, rs2_addr, wrt_en, wrt_addr, wrt_data,
               iss_en, iss_addr, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_cnt
    );

    modport slave (
        input  rs1_addr, rs2_addr, wrt_en, wrt_addr, wrt_data,
               iss_en, iss_addr, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// rv32i integer register file with per-register busy scoreboard.
// Two combinational read ports, one synchronous write port, optional write bypass.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_c;

    logic wr_ok, iss_ok;
    logic rs1_ok, rs2_ok;
    logic rs1_fwd, rs2_fwd;
    logic rs1_iss, rs2_iss;

    // Address 0 and addresses beyond the implemented file are inert.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    assign wr_ok   = !rst && bus.wrt_en && addr_ok(bus.wrt_addr);
    assign iss_ok  = !rst && bus.iss_en && addr_ok(bus.iss_addr);
    assign rs1_ok  = addr_ok(bus.rs1_addr);
    assign rs2_ok  = addr_ok(bus.rs2_addr);
    assign rs1_fwd = (BYPASS != 0) && wr_ok && (bus.wrt_addr == bus.rs1_addr);
    assign rs2_fwd = (BYPASS != 0) && wr_ok && (bus.wrt_addr == bus.rs2_addr);
    assign rs1_iss = iss_ok && (bus.iss_addr == bus.rs1_addr);
    assign rs2_iss = iss_ok && (bus.iss_addr == bus.rs2_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[bus.wrt_addr] <= bus.wrt_data;
        end
    end

    // Clear-on-writeback is applied before set-on-issue so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (wr_ok)  busy_d[bus.wrt_addr] = 1'b0;
            if (iss_ok) busy_d[bus.iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        busy_cnt_c = '0;
        for (int i = 0; i < NREGS; i++) busy_cnt_c = busy_cnt_c + (AW+1)'(busy_q[i]);
    end

    always_comb begin
        bus.rs1_data = '0;
        bus.rs1_busy = 1'b0;
        if (rs1_ok) begin
            bus.rs1_data = rs1_fwd ? bus.wrt_data : regs_q[bus.rs1_addr];
            bus.rs1_busy = (rs1_fwd && !rs1_iss) ? 1'b0 : busy_q[bus.rs1_addr];
        end
    end

    always_comb begin
        bus.rs2_data = '0;
        bus.rs2_busy = 1'b0;
        if (rs2_ok) begin
            bus.rs2_data = rs2_fwd ? bus.wrt_data : regs_q[bus.rs2_addr];
            bus.rs2_busy = (rs2_fwd && !rs2_iss) ? 1'b0 : busy_q[bus.rs2_addr];
        end
    end

    assign bus.busy_cnt = busy_cnt_c;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing 32-entry instance and a
// non-bypassing 16-entry instance driven with identical stimulus.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .AW(5)) ba ();
    regfile_sb_if #(.XLEN(32), .AW(5)) bb ();

    regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ba));
    regfile_sb #(.XLEN(32), .NREGS(16), .AW(5), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bb));

    assign bb.rs1_addr = ba.rs1_addr;
    assign bb.rs2_addr = ba.rs2_addr;
    assign bb.wrt_en   = ba.wrt_en;
    assign bb.wrt_addr = ba.wrt_addr;
    assign bb.wrt_data = ba.wrt_data;
    assign bb.iss_en   = ba.iss_en;
    assign bb.iss_addr = ba.iss_addr;
    assign bb.flush    = ba.flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ba.wrt_en = 1'b0;
        ba.iss_en = 1'b0;
        ba.flush  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ba.wrt_en   = 1'b1;
        ba.wrt_addr = a;
        ba.wrt_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        ba.iss_en   = 1'b1;
        ba.iss_addr = a;
    endtask

    initial begin
        ba.rs1_addr = '0; ba.rs2_addr = '0;
        ba.wrt_addr = '0; ba.wrt_data = '0; ba.iss_addr = '0;
        idle();
        tick(); tick();
        #1;
        chk("rst_cnt", 32'(ba.busy_cnt), 32'd0);
        chk("rst_rs1", ba.rs1_data, 32'd0);
        rst = 1'b0;

        // Async reset between edges wipes x5
        tick();
        wr(5'd5, 32'hDEADBEEF);
        tick();
        idle(); ba.rs1_addr = 5'd5;
        #1;
        chk("x5_written", ba.rs1_data, 32'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("x5_async_rst", ba.rs1_data, 32'd0);
        chk("rst_cnt2", 32'(ba.busy_cnt), 32'd0);
        wr(5'd5, 32'h11111111);
        #1;
        chk("rst_no_bypass", ba.rs1_data, 32'd0);
        tick();
        idle(); rst = 1'b0;
        #1;
        chk("rst_no_write", ba.rs1_data, 32'd0);

        // Write/read and bypass
        tick();
        wr(5'd7, 32'h12345678); ba.rs1_addr = 5'd7;
        #1;
        chk("bypass_a", ba.rs1_data, 32'h12345678);
        chk("nobypass_b", bb.rs1_data, 32'd0);
        tick();
        idle();
        #1;
        chk("stored_a", ba.rs1_data, 32'h12345678);
        chk("stored_b", bb.rs1_data, 32'h12345678);

        // x0 is inert
        wr(5'd0, 32'hFFFFFFFF); iss(5'd0); ba.rs2_addr = 5'd0;
        #1;
        chk("x0_data_same", ba.rs2_data, 32'd0);
        chk("x0_busy_same", 32'(ba.rs2_busy), 32'd0);
        tick();
        idle();
        #1;
        chk("x0_data", ba.rs2_data, 32'd0);
        chk("x0_busy", 32'(ba.rs2_busy), 32'd0);
        chk("x0_cnt", 32'(ba.busy_cnt), 32'd0);

        // Scoreboard set and release
        iss(5'd3);
        tick();
        iss(5'd4);
        tick();
        idle(); ba.rs1_addr = 5'd3; ba.rs2_addr = 5'd4;
        #1;
        chk("sb_cnt2", 32'(ba.busy_cnt), 32'd2);
        chk("sb_x3_busy", 32'(ba.rs1_busy), 32'd1);
        wr(5'd3, 32'h000000A5);
        #1;
        chk("sb_bypass_busy_a", 32'(ba.rs1_busy), 32'd0);
        chk("sb_bypass_busy_b", 32'(bb.rs1_busy), 32'd1);
        chk("sb_bypass_data_a", ba.rs1_data, 32'h000000A5);
        chk("sb_cnt_still2", 32'(ba.busy_cnt), 32'd2);
        tick();
        idle();
        #1;
        chk("sb_cnt1", 32'(ba.busy_cnt), 32'd1);
        chk("sb_x3_free", 32'(ba.rs1_busy), 32'd0);
        chk("sb_x3_data", ba.rs1_data, 32'h000000A5);
        chk("sb_x4_busy", 32'(ba.rs2_busy), 32'd1);

        // Issue and writeback collide on x9
        iss(5'd9);
        tick();
        idle();
        iss(5'd9); wr(5'd9, 32'h00000055); ba.rs1_addr = 5'd9;
        #1;
        chk("col_busy_same", 32'(ba.rs1_busy), 32'd1);
        chk("col_data_same", ba.rs1_data, 32'h00000055);
        tick();
        idle();
        #1;
        chk("col_data", ba.rs1_data, 32'h00000055);
        chk("col_busy", 32'(ba.rs1_busy), 32'd1);
        chk("col_cnt", 32'(ba.busy_cnt), 32'd2);
        chk("col_cnt_b", 32'(bb.busy_cnt), 32'd2);

        // Flush beats issue, write still lands
        iss(5'd1); tick();
        iss(5'd2); tick();
        iss(5'd3); tick();
        idle();
        ba.flush = 1'b1; iss(5'd4); wr(5'd2, 32'h00000077);
        #1;
        chk("fl_cnt_before", 32'(ba.busy_cnt), 32'd5);
        tick();
        idle(); ba.rs1_addr = 5'd4; ba.rs2_addr = 5'd2;
        #1;
        chk("fl_cnt", 32'(ba.busy_cnt), 32'd0);
        chk("fl_x4_free", 32'(ba.rs1_busy), 32'd0);
        chk("fl_x2_data", ba.rs2_data, 32'h00000077);

        // Address 20 is out of range only for the 16-entry instance
        wr(5'd20, 32'h00000099); iss(5'd20);
        tick();
        idle(); ba.rs1_addr = 5'd20;
        #1;
        chk("oor_data_a", ba.rs1_data, 32'h00000099);
        chk("oor_busy_a", 32'(ba.rs1_busy), 32'd1);
        chk("oor_cnt_a", 32'(ba.busy_cnt), 32'd1);
        chk("oor_data_b", bb.rs1_data, 32'd0);
        chk("oor_busy_b", 32'(bb.rs1_busy), 32'd0);
        chk("oor_cnt_b", 32'(bb.busy_cnt), 32'd0);

        // Writeback to a register that was never reserved
        wr(5'd6, 32'h00000066);
        tick();
        idle(); ba.rs2_addr = 5'd6;
        #1;
        chk("nb_data", ba.rs2_data, 32'h00000066);
        chk("nb_busy", 32'(ba.rs2_busy), 32'd0);
        chk("nb_cnt", 32'(ba.busy_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
